// File: rtl/stopwatch_display.sv
// stopwatch_display: per-frame snapshot of sec/min, shift-add-3 BCD conversion, multiplexed MM.SS seven-segment drive
module stopwatch_display #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);
    localparam int SW = $clog2(REFRESH_DIV);
    localparam logic [SW-1:0] LAST  = SW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] BLANK = SW'(BLANK_CYCLES);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t state, state_nx, st;

    logic [SW-1:0] slot;
    logic [1:0]    dig;
    logic          frame_start, blank, lz_off;
    logic [5:0]    sr_s, sr_m;
    logic [7:0]    bcd_s, bcd_m;
    logic [2:0]    cnt;
    logic [3:0]    d0, d1, d2, d3, cur_d;

    function automatic logic [7:0] add3(input logic [7:0] b);
        return {b[7:4] >= 4'd5 ? b[7:4] + 4'd3 : b[7:4], b[3:0] >= 4'd5 ? b[3:0] + 4'd3 : b[3:0]};
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign frame_start = slot == '0 && dig == 2'd0;
    assign blank       = slot < BLANK;
    assign cur_d       = dig == 2'd0 ? d0 : dig == 2'd1 ? d1 : dig == 2'd2 ? d2 : d3;
    assign lz_off      = blank_lz && dig == 2'd3 && d3 == 4'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= '0;
            dig  <= '0;
        end else begin
            slot <= slot == LAST ? '0 : slot + SW'(1);
            if (slot == LAST)
                dig <= dig + 2'd1;
        end
    end

    // LOAD is taken in the frame-start cycle itself so capture lands on slot 0
    always_comb begin
        st       = frame_start ? LOAD : state;
        state_nx = st == LOAD ? SHIFT : st == SHIFT ? (cnt == 3'd5 ? DONE : SHIFT) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr_s  <= '0;
            sr_m  <= '0;
            bcd_s <= '0;
            bcd_m <= '0;
            cnt   <= '0;
            d0    <= '0;
            d1    <= '0;
            d2    <= '0;
            d3    <= '0;
        end else begin
            state <= state_nx;
            if (st == LOAD) begin
                sr_s  <= sec;
                sr_m  <= min;
                bcd_s <= '0;
                bcd_m <= '0;
                cnt   <= '0;
            end
            if (st == SHIFT) begin
                {bcd_s, sr_s} <= {add3(bcd_s), sr_s} << 1;
                {bcd_m, sr_m} <= {add3(bcd_m), sr_m} << 1;
                cnt           <= cnt + 3'd1;
            end
            if (st == DONE) begin
                d0 <= bcd_s[3:0];
                d1 <= bcd_s[7:4];
                d2 <= bcd_m[3:0];
                d3 <= bcd_m[7:4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= 4'hF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an         <= blank || lz_off ? 4'hF : ~(4'b0001 << dig);
            seg        <= blank ? 7'h7F : enc(cur_d);
            dp         <= blank || dig != 2'd2;
            frame_tick <= frame_start;
        end
    end
endmodule

// File: tb/tb_stopwatch_display.sv
// tb_stopwatch_display: directed checks of frame timing, digit drive, snapshot and reset behaviour
module tb_stopwatch_display;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] sec = '0;
    logic [5:0] min = '0;
    logic       blank_lz = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;
    int         cmp_n = 0;
    int         err_n = 0;

    stopwatch_display #(.REFRESH_DIV(20), .BLANK_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .sec(sec), .min(min), .blank_lz(blank_lz),
        .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // expected {an,seg,dp,frame_tick} at frame position p; dv = {d3,d2,d1,d0}
    function automatic logic [12:0] exp_out(input int p, input logic [15:0] dv, input logic lz);
        int         dg = p / 20;
        int         sl = p % 20;
        logic [3:0] dd = dv[dg*4 +: 4];
        logic [3:0] a = 4'hF;
        logic [6:0] s = 7'h7F;
        logic       d = 1'b1;
        if (sl >= 8) begin
            a[dg] = 1'b0;
            if (lz && dg == 3 && dd == 4'd0)
                a = 4'hF;
            s = enc(dd);
            d = dg != 2;
        end
        return {a, s, d, p == 0};
    endfunction

    task automatic start(input logic [5:0] s, input logic [5:0] m, input logic lz);
        sec = s;
        min = m;
        blank_lz = lz;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = {an, seg, dp, frame_tick};
            cmp_n++;
            if (obs !== 13'h1FFE) begin
                err_n++;
                $display("FAIL reset_out cyc=%0d got %h exp %h", i, obs, 13'h1FFE);
            end
        end
        rst = 1'b0;
        for (int n = 1; n <= 170; n++) begin
            @(negedge clk);
            cmp_n++;
            if (frame_tick !== (n % 80 == 1)) begin
                err_n++;
                $display("FAIL reset_tick n=%0d got %b exp %b", n, frame_tick, n % 80 == 1);
            end
        end
    endtask

    task automatic test_digits();
        logic [12:0] obs, exp;
        start(6'd37, 6'd12, 1'b0);
        for (int n = 1; n <= 160; n++) begin
            @(negedge clk);
            obs = {an, seg, dp, frame_tick};
            exp = exp_out((n - 1) % 80, 16'h1237, 1'b0);
            cmp_n++;
            if (obs !== exp) begin
                err_n++;
                $display("FAIL digits n=%0d got %h exp %h", n, obs, exp);
            end
        end
    endtask

    task automatic test_snapshot();
        logic [12:0] obs, exp;
        start(6'd37, 6'd12, 1'b0);
        for (int n = 1; n <= 160; n++) begin
            @(negedge clk);
            obs = {an, seg, dp, frame_tick};
            exp = exp_out((n - 1) % 80, n <= 80 ? 16'h1237 : 16'h1238, 1'b0);
            cmp_n++;
            if (obs !== exp) begin
                err_n++;
                $display("FAIL snapshot n=%0d got %h exp %h", n, obs, exp);
            end
            if (n == 26)
                sec = 6'd38;
        end
    endtask

    task automatic test_leading_zero();
        logic [12:0] obs, exp;
        start(6'd42, 6'd5, 1'b1);
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            obs = {an, seg, dp, frame_tick};
            exp = exp_out(n - 1, 16'h0542, 1'b1);
            cmp_n++;
            if (obs[12:9] !== exp[12:9] || an[3] !== 1'b1) begin
                err_n++;
                $display("FAIL lz_on n=%0d got an %b exp an %b", n, obs[12:9], exp[12:9]);
            end
        end
        blank_lz = 1'b0;
        for (int n = 81; n <= 160; n++) begin
            @(negedge clk);
            obs = {an, seg, dp, frame_tick};
            exp = exp_out((n - 1) % 80, 16'h0542, 1'b0);
            cmp_n++;
            if (obs !== exp) begin
                err_n++;
                $display("FAIL lz_off n=%0d got %h exp %h", n, obs, exp);
            end
        end
    endtask

    task automatic test_boundary();
        logic [12:0] obs, exp;
        start(6'd59, 6'd63, 1'b0);
        for (int n = 1; n <= 160; n++) begin
            @(negedge clk);
            obs = {an, seg, dp, frame_tick};
            exp = exp_out((n - 1) % 80, n <= 80 ? 16'h6359 : 16'h0000, 1'b0);
            cmp_n++;
            if (obs !== exp) begin
                err_n++;
                $display("FAIL boundary n=%0d got %h exp %h", n, obs, exp);
            end
            // this negedge lies in the LOAD cycle of the next frame
            if (n == 80) begin
                sec = 6'd0;
                min = 6'd0;
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [12:0] obs, exp;
        int          rp [2] = '{50, 83};
        for (int k = 0; k < 2; k++) begin
            start(6'd37, 6'd12, 1'b0);
            repeat (rp[k]) @(negedge clk);
            rst = 1'b1;
            sec = 6'd21;
            min = 6'd45;
            @(negedge clk);
            obs = {an, seg, dp, frame_tick};
            cmp_n++;
            if (obs !== 13'h1FFE || {dut.d3, dut.d2, dut.d1, dut.d0} !== 16'h0000) begin
                err_n++;
                $display("FAIL mid_reset_clear at=%0d got %h d=%h exp %h d=0000", rp[k], obs,
                         {dut.d3, dut.d2, dut.d1, dut.d0}, 13'h1FFE);
            end
            rst = 1'b0;
            for (int n = 1; n <= 80; n++) begin
                @(negedge clk);
                obs = {an, seg, dp, frame_tick};
                exp = exp_out(n - 1, 16'h4521, 1'b0);
                cmp_n++;
                if (obs !== exp) begin
                    err_n++;
                    $display("FAIL mid_reset at=%0d n=%0d got %h exp %h", rp[k], n, obs, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_snapshot();
        test_leading_zero();
        test_boundary();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
